// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter; one start bit, DATA_WIDTH data bits LSB first,
// optional parity, one stop bit, each held for Prescale clock cycles.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    input  logic [7:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [7:0]            ps_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  bit_end_d;
    logic                  next_bit_d;

    assign bit_end_d  = cnt_q == ps_q - 8'd1;
    assign next_bit_d = data_q[idx_q + 1'b1];
    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;

    // TX_OUT is registered alongside each state transition, so every bit value
    // appears on the same edge that enters its period.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ps_q     <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            cnt_q <= bit_end_d ? 8'd0 : cnt_q + 8'd1;
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (Data_Valid) begin
                        data_q   <= P_DATA;
                        par_en_q <= Par_En;
                        par_q    <= ^P_DATA ^ Par_Typ;
                        ps_q     <= (Prescale == 8'd0) ? 8'd1 : Prescale;
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end_d) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        tx_q    <= data_q[0];
                    end
                end
                DATA: begin
                    if (bit_end_d) begin
                        if (idx_q == IW'(DATA_WIDTH - 1)) begin
                            state_q <= par_en_q ? PARITY : STOP;
                            tx_q    <= par_en_q ? par_q : 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            tx_q  <= next_bit_d;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end_d) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end_d) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed frame table plus hand-written sequences for
// mid-frame disturbance, back-to-back frames and reset mid-frame.
module tb_uart_tx_frame;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       Par_En = 1'b0;
    logic       Par_Typ = 1'b0;
    logic [7:0] Prescale = 8'd1;
    logic       TX_OUT;
    logic       Busy;

    int total = 0;
    int bad = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .Par_En(Par_En), .Par_Typ(Par_Typ), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // bits[i] is the i-th bit on the line, starting with the start bit.
    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        ptyp;
        logic [7:0]  ps;
        logic [10:0] bits;
        int          ps_eff;
        int          busy;
    } vec_t;

    vec_t tbl[7];
    vec_t v01, v80, v55;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        P_DATA   = v.data;
        Par_En   = v.pen;
        Par_Typ  = v.ptyp;
        Prescale = v.ps;
    endtask

    // Starts at the negedge of the first start-bit cycle; ends at the negedge after Busy falls.
    task automatic check_frame(input vec_t v, input bit disturb, input string tag);
        int n = 0;
        int b;
        while (Busy === 1'b1 && n < 1000) begin
            b = n / v.ps_eff;
            chk($sformatf("%s tx cyc%0d", tag, n), {31'd0, TX_OUT}, {31'd0, (b < 11) ? v.bits[b] : 1'b0});
            if (disturb && n == 20) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'h3C;
                Prescale   = 8'd16;
                Par_En     = 1'b1;
            end
            if (disturb && n == 25) Data_Valid = 1'b0;
            n++;
            @(negedge CLK);
        end
        chk({tag, " busy_len"}, n, v.busy);
        chk({tag, " idle_tx"}, {31'd0, TX_OUT}, 32'd1);
        chk({tag, " idle_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    task automatic send(input vec_t v, input bit disturb, input string tag);
        @(negedge CLK);
        apply(v);
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        check_frame(v, disturb, tag);
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 8'd8, 11'b01101001010, 8, 80};
        tbl[1] = '{8'hA5, 1'b1, 1'b0, 8'd4, 11'b10101001010, 4, 44};
        tbl[2] = '{8'hA5, 1'b1, 1'b1, 8'd4, 11'b11101001010, 4, 44};
        tbl[3] = '{8'hFF, 1'b1, 1'b0, 8'd0, 11'b10111111110, 1, 11};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 8'd1, 11'b10111111110, 1, 11};
        tbl[5] = '{8'h3C, 1'b0, 1'b0, 8'd3, 11'b01001111000, 3, 30};
        tbl[6] = '{8'h01, 1'b1, 1'b1, 8'd2, 11'b10000000010, 2, 22};
        v01    = '{8'h01, 1'b0, 1'b0, 8'd4, 11'b01000000010, 4, 40};
        v80    = '{8'h80, 1'b0, 1'b0, 8'd4, 11'b01100000000, 4, 40};
        v55    = '{8'h55, 1'b0, 1'b0, 8'd4, 11'b01010101010, 4, 40};

        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("reset tx", {31'd0, TX_OUT}, 32'd1);
            chk("reset busy", {31'd0, Busy}, 32'd0);
        end
        RST = 1'b1;
        for (int i = 0; i < 50; i++) begin
            P_DATA = 8'($urandom);
            Par_En = 1'($urandom);
            @(negedge CLK);
            chk($sformatf("idle tx cyc%0d", i), {31'd0, TX_OUT}, 32'd1);
            chk($sformatf("idle busy cyc%0d", i), {31'd0, Busy}, 32'd0);
        end

        for (int i = 0; i < 7; i++) send(tbl[i], 1'b0, $sformatf("vec%0d", i));

        send(tbl[0], 1'b1, "ignore_midframe");

        @(negedge CLK);
        apply(v01);
        Data_Valid = 1'b1;
        @(negedge CLK);
        P_DATA = 8'h80;
        check_frame(v01, 1'b0, "b2b_first");
        @(negedge CLK);
        Data_Valid = 1'b0;
        check_frame(v80, 1'b0, "b2b_second");

        @(negedge CLK);
        apply(tbl[1]);
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (17) @(negedge CLK);
        chk("pre_rst tx", {31'd0, TX_OUT}, 32'd0);
        #2 RST = 1'b0;
        #1;
        chk("async_rst tx", {31'd0, TX_OUT}, 32'd1);
        chk("async_rst busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        send(v55, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter paired with the existing UART receiver path; serialises one byte per request into a start/data/optional-parity/stop frame on TX_OUT.
- Bit period is Prescale CLK cycles, the same Prescale programming the receiver uses.
- Sits between the UART register interface (byte + valid strobe) and the TX pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame, sent LSB first.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  byte to transmit; sampled on acceptance.
- Data_Valid  input  1  transmit request; accepted only while Busy=0.
- Par_En  input  1  1 = insert parity bit after data; sampled on acceptance.
- Par_Typ  input  1  0 = even, 1 = odd; sampled on acceptance.
- Prescale  input  8  CLK cycles per bit; sampled on acceptance.
- TX_OUT  output  1  serial line, idle high.
- Busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.

Behaviour:
- Reset (async, RST=0):
  - State=IDLE; TX_OUT=1; Busy=0.
  - All counters and latched fields are cleared.
  - Applies mid-frame as well: the line returns high immediately and no partial frame resumes.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Acceptance: in IDLE with Data_Valid=1 at edge N, latch the following:
  - P_DATA, Par_En and Par_Typ.
  - Prescale; a value of 0 is latched as 1.
  - The parity bit: XOR-reduce(P_DATA) XOR Par_Typ.
- From edge N+1: TX_OUT=0 (start bit) and Busy=1.
- Data_Valid while Busy=1 is ignored; no queueing.
- Changes to P_DATA, Par_*, or Prescale during a frame have no effect.
- FSM states: IDLE -> START -> DATA -> PARITY (only if latched Par_En=1) -> STOP -> IDLE.
- Bit timing:
  - An 8-bit cycle counter runs 0..Prescale-1 in each non-IDLE state. The state or bit advances when counter = Prescale-1, and the counter then wraps to 0.
  - Each bit is held on TX_OUT for exactly Prescale cycles.
- DATA state:
  - A 3-bit index counts 0..DATA_WIDTH-1 and drives TX_OUT = data[index], LSB first.
  - Leave DATA after index DATA_WIDTH-1 completes its period.
- PARITY: TX_OUT = latched parity bit for one bit period.
- STOP:
  - TX_OUT=1 for one bit period.
  - On its final cycle the next state is IDLE and Busy falls at the following edge.
- Back-to-back frames: with Data_Valid held high, the next frame is accepted in the first IDLE cycle. Exactly one idle-high cycle separates frames: stop bit, then 1 IDLE cycle, then the next start bit.
- Frame length from acceptance to Busy fall:
  - (10 + Par_En) × Prescale cycles.
  - Busy stays high for exactly that many cycles.
- TX_OUT stays 1 in IDLE regardless of input activity.
- The FSM must not enter an undefined state. Unused encodings return to IDLE with TX_OUT=1.

Test Plan:
1. Reset then idle:
   - RST low for 3 cycles, release, no Data_Valid for 50 cycles -> TX_OUT=1 and Busy=0 throughout.
2. Prescale=8, Par_En=0, P_DATA=0xA5, Data_Valid pulsed 1 cycle:
   - TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit held exactly 8 cycles.
   - Busy high for 80 cycles, then low.
3. Parity checks with Prescale=4, P_DATA=0xA5:
   - Par_En=1, Par_Typ=0 -> parity bit 0.
   - Par_Typ=1 -> parity bit 1.
   - Busy=44 cycles; stop bit follows the parity bit.
4. Busy and sampling:
   - Second Data_Valid with P_DATA=0x3C mid-frame -> ignored; only the first byte is sent.
   - Prescale changed 8->16 mid-frame -> remaining bits still 8 cycles each.
   - Data_Valid held high, frames 0x01 then 0x80 -> second start bit begins exactly 1 cycle after the first stop bit ends.
5. Reset mid-frame:
   - Assert RST during the DATA bit index 3 -> TX_OUT=1 and Busy=0 asynchronously.
   - After release, a new 0x55 frame transmits correctly from the start bit.
6. Prescale=0 and Prescale=1 with P_DATA=0xFF, Par_En=1, Par_Typ=0 -> each bit lasts 1 cycle, parity=0, Busy=11 cycles.
